pulse_monitor: RTL and testbench

PULSE_MONITOR -- requirements
Module: pulse_monitor

---
 rtl/pulse_monitor.sv | 110 +++++++++++
 tb/tb_pulse_monitor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pulse_monitor.sv
// Pulse-period monitor: tracks a periodic single-cycle pulse, declares lock after
// LOCK_CNT consecutive on-time intervals and flags early or missing pulses.
module pulse_monitor #(
  parameter int N        = 12500,
  parameter int CBITS    = 14,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             locked,
  output logic             err_early,
  output logic             err_late,
  output logic [7:0]       miss_cnt,
  output logic [CBITS-1:0] interval
);

  typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;

  localparam int               GBITS   = $clog2(LOCK_CNT + 1);
  localparam logic [CBITS-1:0] CNT_N   = CBITS'(N);
  localparam logic [CBITS-1:0] CNT_MAX = '1;
  localparam logic [GBITS-1:0] GCNT_LK = GBITS'(LOCK_CNT);

  state_t           state, state_next;
  logic [CBITS-1:0] cnt;
  logic [GBITS-1:0] gcnt, gcnt_next, gcnt_inc;
  logic             tracking, at_expected;
  logic             early_ev, late_ev, capture;

  assign tracking    = (state != SEARCH);
  assign at_expected = (cnt == CNT_N);
  assign gcnt_inc    = gcnt + GBITS'(1);

  // State register and all registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      cnt       <= '0;
      gcnt      <= '0;
      locked    <= 1'b0;
      err_early <= 1'b0;
      err_late  <= 1'b0;
      miss_cnt  <= '0;
      interval  <= '0;
    end else begin
      state     <= state_next;
      gcnt      <= gcnt_next;
      locked    <= (state_next == LOCKED);
      err_early <= early_ev;
      err_late  <= late_ev;
      if (sig_in)               cnt <= '0;
      else if (cnt != CNT_MAX)  cnt <= cnt + CBITS'(1);
      if ((early_ev || late_ev) && (miss_cnt != 8'hFF))
        miss_cnt <= miss_cnt + 8'd1;
      if (capture)
        interval <= cnt + CBITS'(1);
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path through
  // the case/if tree leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    gcnt_next  = gcnt;
    unique case (state)
      SEARCH: begin
        if (sig_in) begin
          state_next = LOCKING;
          gcnt_next  = '0;
        end
      end
      LOCKING, LOCKED: begin
        if (sig_in && at_expected) begin
          if (state == LOCKING) begin
            gcnt_next = gcnt_inc;
            if (gcnt_inc == GCNT_LK) state_next = LOCKED;
          end
        end else if (sig_in) begin
          // Early pulse restarts timing from this edge.
          gcnt_next  = '0;
          state_next = LOCKING;
        end else if (at_expected) begin
          gcnt_next  = '0;
          state_next = SEARCH;
        end
      end
      default: begin
        state_next = SEARCH;
        gcnt_next  = '0;
      end
    endcase
  end

  // Event decode feeding the registered outputs.
  always_comb begin
    early_ev = 1'b0;
    late_ev  = 1'b0;
    capture  = 1'b0;
    if (tracking) begin
      capture  = sig_in;
      early_ev = sig_in && !at_expected;
      late_ev  = !sig_in && at_expected;
    end
  end

endmodule

// File: tb/tb_pulse_monitor.sv
// Directed bench for pulse_monitor with N=5, LOCK_CNT=4, CBITS=4: lock, early,
// late, stuck-high, async reset and miss counter saturation.
module tb_pulse_monitor;

  localparam int N        = 5;
  localparam int CBITS    = 4;
  localparam int LOCK_CNT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sig_in = 1'b0;
  logic             locked, err_early, err_late;
  logic [7:0]       miss_cnt;
  logic [CBITS-1:0] interval;

  int checks = 0;
  int errors = 0;

  pulse_monitor #(.N(N), .CBITS(CBITS), .LOCK_CNT(LOCK_CNT)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .locked    (locked),
    .err_early (err_early),
    .err_late  (err_late),
    .miss_cnt  (miss_cnt),
    .interval  (interval)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive sig_in for one rising edge, then settle 1 time unit past it.
  task automatic tick(input logic s);
    sig_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  initial begin
    // Reset state, before and across clock edges.
    #1;
    check("rst_async_locked", locked, 0);
    check("rst_async_miss", miss_cnt, 0);
    tick(1'b0);
    tick(1'b1);
    check("rst_locked", locked, 0);
    check("rst_err_early", err_early, 0);
    check("rst_err_late", err_late, 0);
    check("rst_interval", interval, 0);
    rst = 1'b0;

    // Acquire lock: pulses every 6 edges, lock after the 5th pulse.
    tick(1'b1);
    check("first_pulse_interval_hold", interval, 0);
    check("first_pulse_no_err", err_early, 0);
    for (int p = 2; p <= 5; p++) begin
      gap(N);
      tick(1'b1);
      check("acq_interval", interval, 6);
      check("acq_locked", locked, (p == 5) ? 1 : 0);
    end
    check("acq_miss", miss_cnt, 0);

    // Early pulse 4 edges after the previous one.
    gap(3);
    tick(1'b1);
    check("early_flag", err_early, 1);
    check("early_late_clear", err_late, 0);
    check("early_miss", miss_cnt, 1);
    check("early_interval", interval, 4);
    tick(1'b0);
    check("early_one_cycle", err_early, 0);
    check("early_unlock", locked, 0);
    for (int g = 0; g < LOCK_CNT; g++) begin
      gap(g == 0 ? N - 1 : N);
      tick(1'b1);
      check("relock1_locked", locked, (g == LOCK_CNT - 1) ? 1 : 0);
    end
    check("relock1_interval", interval, 6);

    // sig_in stuck high for 3 edges: one good edge, then two early events.
    gap(N);
    tick(1'b1);
    check("stuck_good", err_early, 0);
    check("stuck_good_locked", locked, 1);
    tick(1'b1);
    check("stuck_early1", err_early, 1);
    check("stuck_miss1", miss_cnt, 2);
    tick(1'b1);
    check("stuck_early2", err_early, 1);
    check("stuck_miss2", miss_cnt, 3);
    tick(1'b0);
    check("stuck_early_clear", err_early, 0);
    check("stuck_unlock", locked, 0);
    for (int g = 0; g < LOCK_CNT; g++) begin
      gap(g == 0 ? N - 1 : N);
      tick(1'b1);
    end
    check("relock2_locked", locked, 1);

    // Pulses stop: err_late on the 6th pulse-less edge, then silence.
    gap(N);
    check("late_not_yet", err_late, 0);
    check("late_still_locked", locked, 1);
    tick(1'b0);
    check("late_flag", err_late, 1);
    check("late_early_clear", err_early, 0);
    check("late_miss", miss_cnt, 4);
    tick(1'b0);
    check("late_one_cycle", err_late, 0);
    check("late_unlock", locked, 0);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      check("search_no_late", err_late, 0);
    end
    check("search_miss_hold", miss_cnt, 4);

    // Async reset mid-interval while locked.
    tick(1'b1);
    for (int g = 0; g < LOCK_CNT; g++) begin
      gap(N);
      tick(1'b1);
    end
    check("relock3_locked", locked, 1);
    gap(2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_locked", locked, 0);
    check("async_rst_miss", miss_cnt, 0);
    check("async_rst_interval", interval, 0);
    tick(1'b1);
    check("rst_dominates_interval", interval, 0);
    check("rst_dominates_locked", locked, 0);
    rst = 1'b0;
    gap(2);
    tick(1'b1);
    check("post_rst_no_early", err_early, 0);
    check("post_rst_interval", interval, 0);
    gap(N);
    tick(1'b1);
    check("post_rst_good_interval", interval, 6);
    check("post_rst_miss", miss_cnt, 0);

    // 300 early events: miss_cnt saturates at 255.
    for (int i = 1; i <= 300; i++) begin
      tick(1'b1);
      if (i == 254) check("sat_254", miss_cnt, 254);
      if (i == 255) check("sat_255", miss_cnt, 255);
    end
    check("sat_hold", miss_cnt, 255);
    check("sat_no_late", err_late, 0);
    tick(1'b0);
    check("sat_early_clear", err_early, 0);
    check("sat_hold_after", miss_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
